// File: rtl/regfile_mp.sv
// regfile_mp: multi-port architectural register file for the RV32IMC pipeline.
// NRD combinational read ports, two synchronous write ports (in-order
// writeback on port 0, long-latency writeback on port 1), optional same-cycle
// write-to-read forwarding and a per-register pending scoreboard that tracks
// outstanding long-latency results.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                pend_set_en,
    input  logic [AW-1:0]       pend_set_addr,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    output logic                pend_any
);

    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    // Storage and scoreboard state
    logic [XLEN-1:0]  mem_r [NREGS];
    logic [NREGS-1:0] pend_r;
    logic             pend_any_r;

    // Qualified write / set strobes (x0 writes and sets dropped when hardwired)
    logic             wr0_ok_s;
    logic             wr1_ok_s;
    logic             pend_set_ok_s;
    logic [NREGS-1:0] pend_nxt_s;

    // True when an address refers to a register that can hold state
    function automatic logic addr_live(input logic [AW-1:0] addr);
        addr_live = !(ZERO_REG && (addr == ZERO_ADDR));
    endfunction

    // Qualify the write ports and the pending-set strobe against x0
    always_comb begin
        wr0_ok_s      = wr0_en      && addr_live(wr0_addr);
        wr1_ok_s      = wr1_en      && addr_live(wr1_addr);
        pend_set_ok_s = pend_set_en && addr_live(pend_set_addr);
    end

    // Next scoreboard state: wr1 clear, then flush, then set (set wins last)
    always_comb begin
        pend_nxt_s = pend_r;
        if (wr1_en) begin
            pend_nxt_s[wr1_addr] = 1'b0;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (flush) begin
            pend_nxt_s = {NREGS{1'b0}};
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (pend_set_ok_s) begin
            pend_nxt_s[pend_set_addr] = 1'b1;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (ZERO_REG) begin
            pend_nxt_s[0] = 1'b0;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // Register array update: wr1 first so that wr0 wins on an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (wr1_ok_s) begin
                mem_r[wr1_addr] <= wr1_data;
            end
            if (wr0_ok_s) begin
                mem_r[wr0_addr] <= wr0_data;
            end
        end
    end

    // Scoreboard and registered pend_any summary
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= {NREGS{1'b0}};
            pend_any_r <= 1'b0;
        end else begin
            pend_r     <= pend_nxt_s;
            pend_any_r <= |pend_nxt_s;
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        logic [AW-1:0] a;
        rd_data = {(NRD*XLEN){1'b0}};
        rd_pend = {NRD{1'b0}};
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            if (!addr_live(a)) begin
                rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_pend[p]              = 1'b0;
            end else if (BYPASS) begin
                if (wr0_ok_s && (wr0_addr == a)) begin
                    rd_data[p*XLEN +: XLEN] = wr0_data;
                end else if (wr1_ok_s && (wr1_addr == a)) begin
                    rd_data[p*XLEN +: XLEN] = wr1_data;
                end else begin
                    rd_data[p*XLEN +: XLEN] = mem_r[a];
                end
                if (wr1_en && (wr1_addr == a)) begin
                    rd_pend[p] = 1'b0;
                end else begin
                    rd_pend[p] = pend_r[a];
                end
            end else begin
                rd_data[p*XLEN +: XLEN] = mem_r[a];
                rd_pend[p]              = pend_r[a];
            end
        end
    end

    assign pend_any = pend_any_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (x0 hardwired, bypass on)
// and a variant (x0 writable, bypass off) share stimulus; a narrow 4-port
// instance is exercised with random traffic against a small reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Shared stimulus for instances a and b
    logic        rst;
    logic        wr0_en, wr1_en, pend_set_en, flush;
    logic [4:0]  wr0_addr, wr1_addr, pend_set_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_pend_a, rd_pend_b;
    logic        pend_any_a, pend_any_b;

    regfile_mp dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pend(rd_pend_a), .pend_any(pend_any_a)
    );

    regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pend(rd_pend_b), .pend_any(pend_any_b)
    );

    // Narrow 4-read-port instance
    logic        rst_c;
    logic        wr0_en_c, wr1_en_c, pend_set_en_c, flush_c;
    logic [3:0]  wr0_addr_c, wr1_addr_c, pend_set_addr_c;
    logic [15:0] wr0_data_c, wr1_data_c;
    logic [15:0] rd_addr_c;
    logic [63:0] rd_data_c;
    logic [3:0]  rd_pend_c;
    logic        pend_any_c;

    regfile_mp #(.XLEN(16), .NREGS(16), .AW(4), .NRD(4)) dut_c (
        .clk(clk), .rst(rst_c),
        .wr0_en(wr0_en_c), .wr0_addr(wr0_addr_c), .wr0_data(wr0_data_c),
        .wr1_en(wr1_en_c), .wr1_addr(wr1_addr_c), .wr1_data(wr1_data_c),
        .pend_set_en(pend_set_en_c), .pend_set_addr(pend_set_addr_c), .flush(flush_c),
        .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_pend(rd_pend_c), .pend_any(pend_any_c)
    );

    // Reference model state for instance c
    logic [15:0] mem_m [16];
    logic [15:0] pend_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; pend_set_en = 1'b0; flush = 1'b0;
        wr0_addr = 5'd0; wr1_addr = 5'd0; pend_set_addr = 5'd0;
        wr0_data = 32'd0; wr1_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
        rd_addr = {p1, p0};
        #1;
    endtask

    initial begin
        logic [15:0] exp_d;
        logic        exp_p;
        logic [3:0]  a;
        idle();
        rd_addr = 10'd0;
        rst_c = 1'b1;
        wr0_en_c = 1'b0; wr1_en_c = 1'b0; pend_set_en_c = 1'b0; flush_c = 1'b0;
        wr0_addr_c = 4'd0; wr1_addr_c = 4'd0; pend_set_addr_c = 4'd0;
        wr0_data_c = 16'd0; wr1_data_c = 16'd0; rd_addr_c = 16'd0;

        // Reset with random write / scoreboard traffic
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            wr0_en = 1'b1; wr0_addr = 5'($urandom); wr0_data = $urandom;
            wr1_en = 1'b1; wr1_addr = 5'($urandom); wr1_data = $urandom;
            pend_set_en = 1'b1; pend_set_addr = 5'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            check("rst_data_a", rd_data_a, 64'd0);
            check("rst_data_b", rd_data_b, 64'd0);
            check("rst_pend_a", {62'd0, rd_pend_a}, 64'd0);
            check("rst_pend_b", {62'd0, rd_pend_b}, 64'd0);
        end
        check("rst_pend_any_a", {63'd0, pend_any_a}, 64'd0);
        check("rst_pend_any_b", {63'd0, pend_any_b}, 64'd0);

        // wr0 to x0, x1, x10 on successive cycles
        wr0_en = 1'b1; wr0_data = 32'hADE1B055;
        wr0_addr = 5'd0;  tick();
        wr0_addr = 5'd1;  tick();
        wr0_addr = 5'd10; tick();
        idle();
        set_rd(5'd0, 5'd1);
        check("x0_a", {32'd0, rd_data_a[31:0]}, 64'd0);
        check("x1_a", {32'd0, rd_data_a[63:32]}, 64'hADE1B055);
        check("x0_b", {32'd0, rd_data_b[31:0]}, 64'hADE1B055);
        set_rd(5'd10, 5'd1);
        check("x10_a", {32'd0, rd_data_a[31:0]}, 64'hADE1B055);
        check("x10_b", {32'd0, rd_data_b[31:0]}, 64'hADE1B055);

        // Write collision on x5 with same-cycle read
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h22222222;
        set_rd(5'd5, 5'd5);
        check("coll_byp_a", rd_data_a, {32'h11111111, 32'h11111111});
        check("coll_old_b", rd_data_b, 64'd0);
        tick();
        idle();
        #1;
        check("coll_after_a", rd_data_a, {32'h11111111, 32'h11111111});
        check("coll_after_b", rd_data_b, {32'h11111111, 32'h11111111});

        // wr1-only forwarding, and an x0 write that must not forward
        wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'h33333333;
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h00000055;
        set_rd(5'd6, 5'd0);
        check("wr1_byp_a", rd_data_a, {32'd0, 32'h33333333});
        check("wr1_byp_b", rd_data_b, {32'hADE1B055, 32'd0});
        tick();
        idle();
        #1;
        check("wr1_after_a", rd_data_a, {32'd0, 32'h33333333});
        check("wr1_after_b", rd_data_b, {32'h00000055, 32'h33333333});

        // Scoreboard: set x7, then clear by wr1
        pend_set_en = 1'b1; pend_set_addr = 5'd7;
        set_rd(5'd7, 5'd7);
        check("set_same_cyc_a", {62'd0, rd_pend_a}, 64'd0);
        tick();
        idle();
        #1;
        check("set_pend_a", {62'd0, rd_pend_a}, 64'd3);
        check("set_pend_b", {62'd0, rd_pend_b}, 64'd3);
        check("set_any_a", {63'd0, pend_any_a}, 64'd1);
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hCAFEF00D;
        #1;
        check("clr_pend_a", {62'd0, rd_pend_a}, 64'd0);
        check("clr_data_a", rd_data_a, {32'hCAFEF00D, 32'hCAFEF00D});
        check("clr_any_a", {63'd0, pend_any_a}, 64'd1);
        check("clr_pend_b", {62'd0, rd_pend_b}, 64'd3);
        check("clr_data_b", rd_data_b, 64'd0);
        tick();
        idle();
        #1;
        check("clr_any_next_a", {63'd0, pend_any_a}, 64'd0);
        check("clr_any_next_b", {63'd0, pend_any_b}, 64'd0);
        check("clr_pend_next_b", {62'd0, rd_pend_b}, 64'd0);
        check("clr_data_next_b", rd_data_b, {32'hCAFEF00D, 32'hCAFEF00D});

        // Set/clear race on x3, then flush racing a set of x12
        pend_set_en = 1'b1; pend_set_addr = 5'd3;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h00000003;
        tick();
        idle();
        set_rd(5'd3, 5'd3);
        check("race_a", {62'd0, rd_pend_a}, 64'd3);
        check("race_b", {62'd0, rd_pend_b}, 64'd3);
        pend_set_en = 1'b1; pend_set_addr = 5'd4; tick();
        pend_set_addr = 5'd9; tick();
        idle();
        set_rd(5'd4, 5'd9);
        check("set49_a", {62'd0, rd_pend_a}, 64'd3);
        flush = 1'b1; pend_set_en = 1'b1; pend_set_addr = 5'd12;
        tick();
        idle();
        set_rd(5'd3, 5'd4);
        check("flush_34_a", {62'd0, rd_pend_a}, 64'd0);
        set_rd(5'd9, 5'd12);
        check("flush_9_12_a", {62'd0, rd_pend_a}, 64'd2);
        check("flush_9_12_b", {62'd0, rd_pend_b}, 64'd2);
        check("flush_any_a", {63'd0, pend_any_a}, 64'd1);
        flush = 1'b1; tick(); idle();
        #1;
        check("flush_all_a", {63'd0, pend_any_a}, 64'd0);

        // pend_set on x0
        pend_set_en = 1'b1; pend_set_addr = 5'd0; tick(); idle();
        set_rd(5'd0, 5'd0);
        check("x0_pend_a", {62'd0, rd_pend_a}, 64'd0);
        check("x0_any_a", {63'd0, pend_any_a}, 64'd0);
        check("x0_pend_b", {62'd0, rd_pend_b}, 64'd3);
        check("x0_any_b", {63'd0, pend_any_b}, 64'd1);

        // Reset mid-operation overrides a concurrent write and set
        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h12345678;
        pend_set_en = 1'b1; pend_set_addr = 5'd2;
        tick();
        rst = 1'b0;
        idle();
        set_rd(5'd1, 5'd10);
        check("midrst_data_a", rd_data_a, 64'd0);
        check("midrst_data_b", rd_data_b, 64'd0);
        check("midrst_any_b", {63'd0, pend_any_b}, 64'd0);

        // Random traffic on the 4-port instance against the reference model
        for (int i = 0; i < 16; i++) mem_m[i] = 16'd0;
        pend_m = 16'd0;
        tick();
        rst_c = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst_c           = ($urandom_range(0, 199) == 0);
            wr0_en_c        = 1'($urandom);
            wr0_addr_c      = 4'($urandom);
            wr0_data_c      = 16'($urandom);
            wr1_en_c        = 1'($urandom);
            wr1_addr_c      = 4'($urandom);
            wr1_data_c      = 16'($urandom);
            pend_set_en_c   = ($urandom_range(0, 2) == 0);
            pend_set_addr_c = 4'($urandom);
            flush_c         = ($urandom_range(0, 29) == 0);
            rd_addr_c       = 16'($urandom);
            #1;
            for (int p = 0; p < 4; p++) begin
                a = rd_addr_c[p*4 +: 4];
                if (a == 4'd0) begin
                    exp_d = 16'd0;
                end else if (wr0_en_c && wr0_addr_c == a) begin
                    exp_d = wr0_data_c;
                end else if (wr1_en_c && wr1_addr_c == a) begin
                    exp_d = wr1_data_c;
                end else begin
                    exp_d = mem_m[a];
                end
                exp_p = (a != 4'd0) && !(wr1_en_c && wr1_addr_c == a) && pend_m[a];
                check("sweep_data", {48'd0, rd_data_c[p*16 +: 16]}, {48'd0, exp_d});
                check("sweep_pend", {63'd0, rd_pend_c[p]}, {63'd0, exp_p});
            end
            check("sweep_any", {63'd0, pend_any_c}, {63'd0, |pend_m});
            if (rst_c) begin
                for (int i = 0; i < 16; i++) mem_m[i] = 16'd0;
                pend_m = 16'd0;
            end else begin
                if (wr1_en_c && wr1_addr_c != 4'd0) mem_m[wr1_addr_c] = wr1_data_c;
                if (wr0_en_c && wr0_addr_c != 4'd0) mem_m[wr0_addr_c] = wr0_data_c;
                if (wr1_en_c) pend_m[wr1_addr_c] = 1'b0;
                if (flush_c) pend_m = 16'd0;
                if (pend_set_en_c && pend_set_addr_c != 4'd0) pend_m[pend_set_addr_c] = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
